count_stream_checker: RTL and testbench

- Synthesizable consumer and checker for the free-running up-counter stream used across fft_cim. It is the read end of the counter interface: it samples the counter value every clock and verifies that the value steps by +1 modulo 2^WIDTH.
- It reports lock status, errors and wrap events.
- It is placed beside counter-driven sequencers (FFT stage and address counters) so benches and on-chip debug get a pass/fail result without waveform inspection.

---
 rtl/count_stream_if.sv | 41 ++++
 rtl/count_stream_checker.sv | 170 +++++++++++++++++
 tb/tb_count_stream_checker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_stream_if.sv
// Bundles the monitored counter sample, its qualifiers and the checker's status outputs.
// Optional first-error capture signals exist only when COUNT_CHK_FIRST_ERR_EN is defined.
interface count_stream_if #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 16
);
  // Sampling protocol: count_in is sampled on every rising clk edge while en=1;
  // there is no backpressure, and clr acts on the same edge it is seen high.
  logic                  en;
  logic                  clr;
  logic [WIDTH-1:0]      count_in;
  logic                  locked;
  logic                  err_pulse;
  logic                  fail;
  logic [ERR_CNT_W-1:0]  err_cnt;
  logic [WRAP_CNT_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]      exp_count;
  logic [1:0]            state_dbg;
`ifdef COUNT_CHK_FIRST_ERR_EN
  logic                  first_err_vld;
  logic [WIDTH-1:0]      first_err_exp;
  logic [WIDTH-1:0]      first_err_got;
`endif

  modport master (
    output en, clr, count_in,
    input  locked, err_pulse, fail, err_cnt, wrap_cnt, exp_count, state_dbg
`ifdef COUNT_CHK_FIRST_ERR_EN
    , first_err_vld, first_err_exp, first_err_got
`endif
  );

  modport slave (
    input  en, clr, count_in,
    output locked, err_pulse, fail, err_cnt, wrap_cnt, exp_count, state_dbg
`ifdef COUNT_CHK_FIRST_ERR_EN
    , first_err_vld, first_err_exp, first_err_got
`endif
  );
endinterface

// File: rtl/count_stream_checker.sv
// Checks that a free-running counter steps by +1 mod 2^WIDTH; reports lock, errors, wraps.
// Optional first-error capture is enabled by defining COUNT_CHK_FIRST_ERR_EN.
module count_stream_checker #(
  parameter int WIDTH      = 4,
  parameter int SYNC_LEN   = 2,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 16
) (
  input logic           clk,
  input logic           rstn,
  count_stream_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  localparam logic [3:0]           SYNC_LEN_C = 4'(SYNC_LEN);
  localparam logic [WIDTH-1:0]     CNT_MAX    = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic [3:0]            good_q, good_d;
  logic                  locked_q, locked_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  fail_q, fail_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH-1:0]      exp_count_q, exp_count_d;
`ifdef COUNT_CHK_FIRST_ERR_EN
  logic                  fe_vld_q, fe_vld_d;
  logic [WIDTH-1:0]      fe_exp_q, fe_exp_d;
  logic [WIDTH-1:0]      fe_got_q, fe_got_d;
`endif

  logic [WIDTH-1:0] prev_inc;
  logic             match;
  logic [3:0]       good_inc;

  assign prev_inc = prev_q + WIDTH'(1);
  assign match    = (bus.count_in == prev_inc);
  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    fail_d      = fail_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
`ifdef COUNT_CHK_FIRST_ERR_EN
    fe_vld_d    = fe_vld_q;
    fe_exp_d    = fe_exp_q;
    fe_got_d    = fe_got_q;
`endif
    if (!bus.en) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          locked_d = 1'b0;
          prev_d   = bus.count_in;
          good_d   = 4'd0;
          state_d  = ST_SYNC;
        end
        ST_SYNC: begin
          prev_d = bus.count_in;
          good_d = match ? good_inc : 4'd0;
          if (match && (good_inc == SYNC_LEN_C)) begin
            state_d  = ST_TRACK;
            locked_d = 1'b1;
            good_d   = 4'd0;
          end
        end
        ST_TRACK: begin
          prev_d = bus.count_in;
          if (match) begin
            // A match out of the all-ones value is by construction the max->0 wrap.
            if (prev_q == CNT_MAX) wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
          end else begin
            err_pulse_d = 1'b1;
            fail_d      = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            good_d      = 4'd0;
            locked_d    = 1'b0;
            state_d     = ST_SYNC;
`ifdef COUNT_CHK_FIRST_ERR_EN
            if (!fe_vld_q) begin
              fe_vld_d = 1'b1;
              fe_exp_d = prev_inc;
              fe_got_d = bus.count_in;
            end
`endif
          end
        end
        default: begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
    // Clear wins over a same-edge error/wrap update, but err_pulse still reports the error.
    if (bus.clr) begin
      fail_d     = 1'b0;
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
`ifdef COUNT_CHK_FIRST_ERR_EN
      fe_vld_d   = 1'b0;
      fe_exp_d   = '0;
      fe_got_d   = '0;
`endif
    end
  end

  assign exp_count_d = prev_d + WIDTH'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      good_q      <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      exp_count_q <= WIDTH'(1);
`ifdef COUNT_CHK_FIRST_ERR_EN
      fe_vld_q    <= 1'b0;
      fe_exp_q    <= '0;
      fe_got_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      fail_q      <= fail_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      exp_count_q <= exp_count_d;
`ifdef COUNT_CHK_FIRST_ERR_EN
      fe_vld_q    <= fe_vld_d;
      fe_exp_q    <= fe_exp_d;
      fe_got_q    <= fe_got_d;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.fail      = fail_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.wrap_cnt  = wrap_cnt_q;
  assign bus.exp_count = exp_count_q;
  assign bus.state_dbg = state_q;
`ifdef COUNT_CHK_FIRST_ERR_EN
  assign bus.first_err_vld = fe_vld_q;
  assign bus.first_err_exp = fe_exp_q;
  assign bus.first_err_got = fe_got_q;
`endif

endmodule

// File: tb/tb_count_stream_checker.sv
// Randomized scoreboard bench for count_stream_checker against a behavioural model.
// Honors COUNT_CHK_FIRST_ERR_EN when defined for the build.
module tb_count_stream_checker;
  localparam int W   = 4;
  localparam int SL  = 2;
  localparam int EW  = 2;
  localparam int WW  = 3;
  localparam int M   = 1 << W;
  localparam int EM  = (1 << EW) - 1;
  localparam int WM  = 1 << WW;
`ifdef COUNT_CHK_FIRST_ERR_EN
  localparam int OW  = 3 + EW + WW + W + 1 + 2 * W;
`else
  localparam int OW  = 3 + EW + WW + W;
`endif

  logic clk;
  logic rstn;
  count_stream_if #(.WIDTH(W), .ERR_CNT_W(EW), .WRAP_CNT_W(WW)) bus ();

  count_stream_checker #(.WIDTH(W), .SYNC_LEN(SL), .ERR_CNT_W(EW), .WRAP_CNT_W(WW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // mode: 0 = not sampling, 1 = hunting for SL consecutive increments, 2 = locked
  int m_mode, m_prev, m_good, m_locked, m_pulse, m_fail, m_err, m_wrap;
  int fe_vld, fe_exp, fe_got;

  function automatic void model_reset();
    m_mode = 0; m_prev = 0; m_good = 0; m_locked = 0; m_pulse = 0;
    m_fail = 0; m_err = 0; m_wrap = 0; fe_vld = 0; fe_exp = 0; fe_got = 0;
  endfunction

  function automatic void model_step(input int e, input int c, input int v);
    int nxt;
    nxt = (m_prev + 1) % M;
    m_pulse = 0;
    if (e == 0) begin
      m_mode = 0; m_locked = 0;
    end else if (m_mode == 0) begin
      m_prev = v; m_good = 0; m_mode = 1;
    end else if (m_mode == 1) begin
      m_good = (v == nxt) ? m_good + 1 : 0;
      m_prev = v;
      if (m_good == SL) begin m_mode = 2; m_locked = 1; m_good = 0; end
    end else begin
      if (v == nxt) begin
        if (m_prev == M - 1) m_wrap = (m_wrap + 1) % WM;
      end else begin
        m_pulse = 1; m_fail = 1;
        m_err = (m_err + 1 > EM) ? EM : m_err + 1;
        if (fe_vld == 0) begin fe_vld = 1; fe_exp = nxt; fe_got = v; end
        m_good = 0; m_mode = 1; m_locked = 0;
      end
      m_prev = v;
    end
    if (c != 0) begin
      m_err = 0; m_wrap = 0; m_fail = 0; fe_vld = 0; fe_exp = 0; fe_got = 0;
    end
  endfunction

  function automatic logic [OW-1:0] model_pack();
    return {1'(m_locked), 1'(m_pulse), 1'(m_fail), EW'(m_err), WW'(m_wrap), W'((m_prev + 1) % M)
`ifdef COUNT_CHK_FIRST_ERR_EN
            , 1'(fe_vld), W'(fe_exp), W'(fe_got)
`endif
           };
  endfunction

  function automatic logic [OW-1:0] dut_pack();
    return {bus.locked, bus.err_pulse, bus.fail, bus.err_cnt, bus.wrap_cnt, bus.exp_count
`ifdef COUNT_CHK_FIRST_ERR_EN
            , bus.first_err_vld, bus.first_err_exp, bus.first_err_got
`endif
           };
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  task automatic check_vec(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h (state_dbg %0d)",
                  name, cycle, got, exp, bus.state_dbg);
  endtask

  always @(posedge clk) begin
    cycle++;
    #1;
    if (exp_q.size() > 0) check_vec("outputs", dut_pack(), exp_q.pop_front());
  end

  // ---------------- driver ----------------
  int src;

  task automatic step(input int e, input int c, input int v);
    @(negedge clk);
    bus.en       = 1'(e);
    bus.clr      = 1'(c);
    bus.count_in = W'(v);
    model_step(e, c, v);
    exp_q.push_back(model_pack());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      src = (src + 1) % M;
      step(1, 0, src);
    end
  endtask

  task automatic skip_err(input int c);
    src = (src + 2) % M;
    step(1, c, src);
  endtask

  // Asserts reset away from any clock edge and checks outputs before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    bus.en  = 1'b0;
    bus.clr = 1'b0;
    rstn    = 1'b0;
    #1;
    model_reset();
    check_vec("async_reset", dut_pack(), model_pack());
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    rstn = 1'b1;
    bus.en = 1'b1;
    bus.clr = 1'b0;
    bus.count_in = W'(9);
    #1 rstn = 1'b0;
    #1 check_vec("reset_no_clock", dut_pack(), model_pack());
    bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // lock and two wraps over 36 samples
    src = M - 1;
    run(36);
    // skip error 6 -> 8 then relock on 9, 10
    run((6 - src + M) % M);
    src = 7;
    run(3);
    run(3);
    // five separate skips push the 2-bit error count into saturation
    for (int k = 0; k < 5; k++) begin
      skip_err(0);
      run(4);
    end
    // clear on the same edge as a bad sample
    run(2);
    skip_err(1);
    run(5);
    // disable while locked, then relock
    for (int k = 0; k < 3; k++) begin
      src = (src + 1) % M;
      step(0, 0, src);
    end
    run(6);
    // asynchronous reset while locked
    async_reset();
    src = $urandom_range(0, M - 1);
    run(5);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 999);
      if (r < 780) run(1);
      else if (r < 850) begin
        src = $urandom_range(0, M - 1);
        step(1, 0, src);
      end else if (r < 900) step(1, 0, src);
      else if (r < 950) begin
        src = (src + 1) % M;
        step(0, $urandom_range(0, 1), src);
      end else if (r < 990) begin
        src = (src + 1) % M;
        step(1, 1, src);
      end else if (r < 996) skip_err(1);
      else begin
        async_reset();
        src = $urandom_range(0, M - 1);
        run(1);
      end
    end

    step(0, 0, src);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
